// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage RAW scoreboard driving stall and EXE/MEM forward selects
// Tracks in-flight producers per register with a 2-step age; register 0 is never tracked.
module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter bit BR_FWD_MEM = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             freeze_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] src1_i,
  input  logic [REG_W-1:0] src2_i,
  input  logic             src2_used_i,
  input  logic             is_br_i,
  input  logic [REG_W-1:0] id_dest_i,
  input  logic             id_wb_en_i,
  input  logic             id_mem_r_en_i,
  output logic             hazard_detected_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] fwd_count_o
);

  localparam int NUM_REGS = 2**REG_W;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXE = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic [NUM_REGS-1:0]      pend_q, pend_d;
  logic [NUM_REGS-1:0]      is_ld_q, is_ld_d;
  logic [NUM_REGS-1:0][1:0] age_q, age_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]         fwd_cnt_q, fwd_cnt_d;
  logic                     haz_a, haz_b, hazard, issue;
  logic [1:0]               sel_a, sel_b;

  // Returns {hazard, sel}; a pending entry is only ever age 1 (in EXE) or age 2 (in MEM).
  function automatic logic [2:0] eval_src(input logic pend, input logic [1:0] age,
                                          input logic ld, input logic br);
    logic [2:0] res;
    res = {1'b0, SEL_RF};
    if (pend) begin
      if (age == 2'd1) begin
        if (!ld && FWD_EN && !br) res = {1'b0, SEL_EXE};
        else                      res = {1'b1, SEL_RF};
      end else begin
        if (FWD_EN && (!br || BR_FWD_MEM)) res = {1'b0, SEL_MEM};
        else                               res = {1'b1, SEL_RF};
      end
    end
    return res;
  endfunction

  always_comb begin
    haz_b = 1'b0;
    sel_b = SEL_RF;
    {haz_a, sel_a} = eval_src(pend_q[src1_i], age_q[src1_i], is_ld_q[src1_i], is_br_i);
    if (src2_used_i) begin
      {haz_b, sel_b} = eval_src(pend_q[src2_i], age_q[src2_i], is_ld_q[src2_i], is_br_i);
    end
    hazard = id_valid_i & (haz_a | haz_b);
    issue  = id_valid_i & ~hazard & ~freeze_i & ~flush_i;
  end

  always_comb begin
    pend_d  = pend_q;
    age_d   = age_q;
    is_ld_d = is_ld_q;
    if (!freeze_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue && id_wb_en_i && id_dest_i == REG_W'(r)) begin
          pend_d[r]  = 1'b1;
          age_d[r]   = 2'd1;
          is_ld_d[r] = id_mem_r_en_i;
        end else if (pend_q[r]) begin
          if (age_q[r] == 2'd1) begin
            age_d[r] = 2'd2;
          end else begin
            // WB writes the regfile before ID reads, so the entry retires here.
            pend_d[r] = 1'b0;
            age_d[r]  = 2'd0;
          end
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (hazard && !freeze_i && !flush_i && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (issue && (sel_a != SEL_RF || sel_b != SEL_RF) && fwd_cnt_q != '1) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q      <= '0;
      age_q       <= '0;
      is_ld_q     <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      pend_q      <= pend_d;
      age_q       <= age_d;
      is_ld_q     <= is_ld_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign hazard_detected_o = hazard;
  assign fwd_a_sel_o       = hazard ? SEL_RF : sel_a;
  assign fwd_b_sel_o       = hazard ? SEL_RF : sel_b;
  assign stall_count_o     = stall_cnt_q;
  assign fwd_count_o       = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench for hazard_scoreboard against a distance model
module tb_hazard_scoreboard;

  localparam int REG_W = 5;
  localparam int NR    = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             freeze_i, flush_i, id_valid_i, src2_used_i, is_br_i;
  logic             id_wb_en_i, id_mem_r_en_i;
  logic [REG_W-1:0] src1_i, src2_i, id_dest_i;

  logic        haz0, haz1, haz2;
  logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
  logic [2:0]  sc2, fc2;

  int errors = 0;
  int checks = 0;

  // Model: each register remembers the tick (non-frozen edge count) of its latest writer.
  int   fwd_en_c [3] = '{1, 0, 1};
  int   br_mem_c [3] = '{0, 0, 1};
  int   cnt_max  [3] = '{65535, 15, 7};
  logic wr_v  [3][NR];
  int   wr_t  [3][NR];
  logic wr_ld [3][NR];
  int   tick;
  int   sc_m [3];
  int   fc_m [3];
  logic       eh [3];
  logic [1:0] ea [3];
  logic [1:0] eb [3];

  always #5 clk_i = ~clk_i;

  hazard_scoreboard #(.REG_W(REG_W), .FWD_EN(1'b1), .BR_FWD_MEM(1'b0), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .freeze_i(freeze_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .src1_i(src1_i), .src2_i(src2_i), .src2_used_i(src2_used_i),
    .is_br_i(is_br_i), .id_dest_i(id_dest_i), .id_wb_en_i(id_wb_en_i),
    .id_mem_r_en_i(id_mem_r_en_i), .hazard_detected_o(haz0), .fwd_a_sel_o(fa0),
    .fwd_b_sel_o(fb0), .stall_count_o(sc0), .fwd_count_o(fc0));

  hazard_scoreboard #(.REG_W(REG_W), .FWD_EN(1'b0), .BR_FWD_MEM(1'b0), .CNT_W(4)) u_dut_nofwd (
    .clk_i(clk_i), .rst_ni(rst_ni), .freeze_i(freeze_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .src1_i(src1_i), .src2_i(src2_i), .src2_used_i(src2_used_i),
    .is_br_i(is_br_i), .id_dest_i(id_dest_i), .id_wb_en_i(id_wb_en_i),
    .id_mem_r_en_i(id_mem_r_en_i), .hazard_detected_o(haz1), .fwd_a_sel_o(fa1),
    .fwd_b_sel_o(fb1), .stall_count_o(sc1), .fwd_count_o(fc1));

  hazard_scoreboard #(.REG_W(REG_W), .FWD_EN(1'b1), .BR_FWD_MEM(1'b1), .CNT_W(3)) u_dut_brmem (
    .clk_i(clk_i), .rst_ni(rst_ni), .freeze_i(freeze_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .src1_i(src1_i), .src2_i(src2_i), .src2_used_i(src2_used_i),
    .is_br_i(is_br_i), .id_dest_i(id_dest_i), .id_wb_en_i(id_wb_en_i),
    .id_mem_r_en_i(id_mem_r_en_i), .hazard_detected_o(haz2), .fwd_a_sel_o(fa2),
    .fwd_b_sel_o(fb2), .stall_count_o(sc2), .fwd_count_o(fc2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int m);
    return (v >= m) ? v : v + 1;
  endfunction

  function automatic void eval_op(input int k, input logic [REG_W-1:0] s, input logic used,
                                  output logic h, output logic [1:0] sel);
    int d;
    h   = 1'b0;
    sel = 2'b00;
    if (!used || s == 0 || !wr_v[k][s]) return;
    d = tick - wr_t[k][s];
    if (d == 1) begin
      if (wr_ld[k][s] || fwd_en_c[k] == 0 || is_br_i) h = 1'b1;
      else sel = 2'b01;
    end else if (d == 2) begin
      if (fwd_en_c[k] == 1 && (!is_br_i || br_mem_c[k] == 1)) sel = 2'b10;
      else h = 1'b1;
    end
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < NR; r++) wr_v[k][r] = 1'b0;
      sc_m[k] = 0;
      fc_m[k] = 0;
    end
  endtask

  task automatic check_cfg(input int k, input logic h, input logic [1:0] a, input logic [1:0] b,
                           input logic [15:0] sc, input logic [15:0] fc);
    check_val($sformatf("c%0d_hazard", k), 32'(h), 32'(eh[k]));
    check_val($sformatf("c%0d_fwd_a", k), 32'(a), 32'(ea[k]));
    check_val($sformatf("c%0d_fwd_b", k), 32'(b), 32'(eb[k]));
    check_val($sformatf("c%0d_stall_cnt", k), 32'(sc), sc_m[k]);
    check_val($sformatf("c%0d_fwd_cnt", k), 32'(fc), fc_m[k]);
  endtask

  task automatic sample();
    logic h1, h2;
    logic [1:0] s1, s2;
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      eval_op(k, src1_i, 1'b1, h1, s1);
      eval_op(k, src2_i, src2_used_i, h2, s2);
      eh[k] = id_valid_i && (h1 || h2);
      ea[k] = eh[k] ? 2'b00 : s1;
      eb[k] = eh[k] ? 2'b00 : s2;
    end
    check_cfg(0, haz0, fa0, fb0, sc0, fc0);
    check_cfg(1, haz1, fa1, fb1, {12'b0, sc1}, {12'b0, fc1});
    check_cfg(2, haz2, fa2, fb2, {13'b0, sc2}, {13'b0, fc2});
  endtask

  task automatic advance();
    logic iss;
    @(posedge clk_i);
    if (rst_ni && !freeze_i) begin
      for (int k = 0; k < 3; k++) begin
        iss = id_valid_i && !eh[k] && !flush_i;
        if (eh[k] && !flush_i) sc_m[k] = sat_inc(sc_m[k], cnt_max[k]);
        if (iss && (ea[k] != 2'b00 || eb[k] != 2'b00)) fc_m[k] = sat_inc(fc_m[k], cnt_max[k]);
        if (iss && id_wb_en_i && id_dest_i != 0) begin
          wr_v[k][id_dest_i]  = 1'b1;
          wr_t[k][id_dest_i]  = tick;
          wr_ld[k][id_dest_i] = id_mem_r_en_i;
        end
      end
      tick++;
    end
    #1;
  endtask

  task automatic drive(input logic v, input int s1, input int s2, input logic used,
                       input logic br, input int dest, input logic wb, input logic ld);
    id_valid_i    = v;
    src1_i        = REG_W'(s1);
    src2_i        = REG_W'(s2);
    src2_used_i   = used;
    is_br_i       = br;
    id_dest_i     = REG_W'(dest);
    id_wb_en_i    = wb;
    id_mem_r_en_i = ld;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  initial begin
    tick = 0;
    reset_model();
    rst_ni   = 1'b0;
    freeze_i = 1'b0;
    flush_i  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    step();
    rst_ni = 1'b1;

    // ALU producer r3: EXE forward, then MEM forward, then regfile
    drive(1, 0, 0, 0, 0, 3, 1, 0); step();
    drive(1, 3, 0, 0, 0, 8, 1, 0);
    sample(); check_val("alu_exe_fwd", 32'(fa0), 32'd1); check_val("alu_no_stall", 32'(haz0), 32'd0);
    advance();
    sample(); check_val("alu_mem_fwd", 32'(fa0), 32'd2); advance();
    sample(); check_val("alu_regfile", 32'(fa0), 32'd0); advance();
    idle();

    // load-use on src2: one stall then MEM forward
    drive(1, 0, 0, 0, 0, 5, 1, 1); step();
    drive(1, 0, 5, 1, 0, 0, 0, 0);
    sample(); check_val("ld_use_stall", 32'(haz0), 32'd1); advance();
    sample(); check_val("ld_use_release", 32'(haz0), 32'd0);
    check_val("ld_use_fwd_b", 32'(fb0), 32'd2); check_val("ld_use_stall_cnt", 32'(sc0), 32'd1);
    advance();
    idle();

    // branch on r7 right behind its ALU producer
    drive(1, 0, 0, 0, 0, 7, 1, 0); step();
    drive(1, 7, 0, 0, 1, 0, 0, 0);
    sample(); check_val("br_stall1", 32'(haz0), 32'd1); check_val("br_mem_stall1", 32'(haz2), 32'd1);
    advance();
    sample(); check_val("br_stall2", 32'(haz0), 32'd1); check_val("br_mem_go", 32'(haz2), 32'd0);
    check_val("br_mem_fwd", 32'(fa2), 32'd2);
    advance();
    sample(); check_val("br_go", 32'(haz0), 32'd0); check_val("br_regfile", 32'(fa0), 32'd0);
    advance();
    idle();

    // forwarding disabled: two stalls; r0 and unused src2 never stall
    drive(1, 0, 0, 0, 0, 4, 1, 0); step();
    drive(1, 4, 0, 0, 0, 0, 0, 0);
    sample(); check_val("nofwd_stall1", 32'(haz1), 32'd1); advance();
    sample(); check_val("nofwd_stall2", 32'(haz1), 32'd1); advance();
    sample(); check_val("nofwd_go", 32'(haz1), 32'd0); advance();
    drive(1, 0, 0, 0, 0, 4, 1, 0); step();
    drive(1, 0, 4, 0, 0, 0, 0, 0);
    sample(); check_val("nofwd_src2_unused", 32'(haz1), 32'd0); advance();
    drive(1, 0, 0, 0, 0, 0, 1, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample(); check_val("nofwd_r0", 32'(haz1), 32'd0); advance();
    idle();

    // load then ALU writer of r6: newer ALU entry dominates, held across freeze
    drive(1, 0, 0, 0, 0, 6, 1, 1); step();
    drive(1, 0, 0, 0, 0, 6, 1, 0); step();
    drive(1, 6, 0, 0, 0, 0, 0, 0);
    freeze_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(); check_val($sformatf("frz%0d_fwd_a", i), 32'(fa0), 32'd1);
      check_val($sformatf("frz%0d_haz", i), 32'(haz0), 32'd0);
      advance();
    end
    freeze_i = 1'b0;
    sample(); check_val("unfrz_fwd_a", 32'(fa0), 32'd1); advance();
    idle();

    // asynchronous reset with a pending load and nonzero counters
    drive(1, 0, 0, 0, 0, 9, 1, 1); step();
    drive(1, 9, 0, 0, 0, 0, 0, 0);
    sample(); check_val("pre_rst_haz", 32'(haz0), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_val("rst_haz0", 32'(haz0), 32'd0); check_val("rst_fa0", 32'(fa0), 32'd0);
    check_val("rst_sc0", 32'(sc0), 32'd0); check_val("rst_fc0", 32'(fc0), 32'd0);
    check_val("rst_sc1", 32'(sc1), 32'd0); check_val("rst_sc2", 32'(sc2), 32'd0);
    check_val("rst_haz1", 32'(haz1), 32'd0); check_val("rst_haz2", 32'(haz2), 32'd0);
    reset_model();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    sample(); check_val("post_rst_haz", 32'(haz0), 32'd0); check_val("post_rst_fa", 32'(fa0), 32'd0);
    advance();
    idle();

    // randomized traffic over a small register window to force collisions
    repeat (600) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));
      freeze_i = ($urandom_range(0, 9) == 0);
      flush_i  = ($urandom_range(0, 9) == 0);
      step();
    end
    freeze_i = 1'b0;
    flush_i  = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
